// File: rtl/serial_pkg.sv
// Shared definitions for the single-bit serial link blocks: FSM state
// encoding, the idle level of the line and a counter-width helper.
package serial_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam logic LINE_IDLE = 1'b1;

   // Counter width for a modulus of n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_bit_tx_bit_timer.sv
// Bit-period timer: counts clk cycles while enabled and flags the last
// cycle of each bit period. The FSM clears it when a word is accepted so
// every frame starts on a fresh bit period.
module bit_timer
   import serial_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_bit_end
);

   localparam int CNT_W = cnt_width(BIT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] r_bit_cnt;
   logic             w_at_max;

   assign w_at_max  = (r_bit_cnt == CNT_MAX);
   assign o_bit_end = i_en & w_at_max;

   // Cycle counter within a bit, wrapping to 0 on each bit boundary.
   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_bit_cnt <= '0;
      end else if (i_en) begin
         if (w_at_max) begin
            r_bit_cnt <= '0;
         end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/serial_bit_tx.sv
// Framed serial transmitter: takes a parallel word on a valid/ready
// handshake and sends start bit (0), DATA_W data bits LSB-first and a stop
// bit (1), each held for BIT_CYCLES clocks. All outputs are registers
// loaded from the next-state decode, so nothing reaches the pins
// combinationally from the inputs and the line never glitches.
module serial_bit_tx
   import serial_pkg::*;
#(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              out,
   output logic              busy,
   output logic              done
);

   localparam int IDX_W = cnt_width(DATA_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [DATA_W-1:0] r_shift;
   logic [DATA_W-1:0] w_shift_nxt;
   logic [IDX_W-1:0]  r_idx;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic              w_accept;
   logic              w_bit_end;
   logic              w_timer_en;
   logic              w_done_nxt;
   logic              w_out_nxt;
   logic              r_out;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;

   // tx_ready is high exactly when the registered state is IDLE.
   assign w_accept   = tx_valid & r_ready;
   assign w_timer_en = (r_state != IDLE);

   bit_timer #(
      .BIT_CYCLES(BIT_CYCLES)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .i_en     (w_timer_en),
      .i_clr    (w_accept),
      .o_bit_end(w_bit_end)
   );

   // State register; reset (also mid-frame) drops straight back to IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, shift register and bit-index update, plus done request.
   always_comb begin
      w_state_nxt = r_state;
      w_shift_nxt = r_shift;
      w_idx_nxt   = r_idx;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt = START;
               w_shift_nxt = tx_data;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt = DATA;
               w_idx_nxt   = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               if (r_idx == IDX_LAST) begin
                  w_state_nxt = STOP;
               end else begin
                  w_idx_nxt   = r_idx + IDX_W'(1);
                  w_shift_nxt = r_shift >> 1;
               end
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_state_nxt = IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Line level for the state being entered, so out changes on the same
   // edge as the state.
   always_comb begin
      w_out_nxt = LINE_IDLE;
      case (w_state_nxt)
         START:   w_out_nxt = 1'b0;
         DATA:    w_out_nxt = w_shift_nxt[0];
         default: w_out_nxt = LINE_IDLE;
      endcase
   end

   // Shift register holds the word only; the bit index is a counter and resets.
   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
      if (rst) begin
         r_idx <= '0;
      end else begin
         r_idx <= w_idx_nxt;
      end
   end

   // Registered output decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= LINE_IDLE;
         r_ready <= 1'b1;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_out   <= w_out_nxt;
         r_ready <= (w_state_nxt == IDLE);
         r_busy  <= (w_state_nxt != IDLE);
         r_done  <= w_done_nxt;
      end
   end

   assign out      = r_out;
   assign tx_ready = r_ready;
   assign busy     = r_busy;
   assign done     = r_done;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: three instances with different DATA_W/BIT_CYCLES
// share clk and rst; frames are checked cycle by cycle against a frame
// model and decoded by a mid-bit sampling receiver.
module tb_serial_bit_tx;

   logic       clk;
   logic       rst;
   logic [7:0] dat_a [3];
   logic       vld_a [3];
   logic       rdy_a [3];
   logic       out_a [3];
   logic       busy_a [3];
   logic       done_a [3];

   int dw_a [3] = '{8, 4, 8};
   int bc_a [3] = '{4, 1, 3};

   int n_chk = 0;
   int n_err = 0;

   serial_bit_tx #(.DATA_W(8), .BIT_CYCLES(4)) u_d0 (
      .clk(clk), .rst(rst), .tx_data(dat_a[0]), .tx_valid(vld_a[0]),
      .tx_ready(rdy_a[0]), .out(out_a[0]), .busy(busy_a[0]), .done(done_a[0]));

   serial_bit_tx #(.DATA_W(4), .BIT_CYCLES(1)) u_d1 (
      .clk(clk), .rst(rst), .tx_data(dat_a[1][3:0]), .tx_valid(vld_a[1]),
      .tx_ready(rdy_a[1]), .out(out_a[1]), .busy(busy_a[1]), .done(done_a[1]));

   serial_bit_tx #(.DATA_W(8), .BIT_CYCLES(3)) u_d2 (
      .clk(clk), .rst(rst), .tx_data(dat_a[2]), .tx_valid(vld_a[2]),
      .tx_ready(rdy_a[2]), .out(out_a[2]), .busy(busy_a[2]), .done(done_a[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Line level at cycle c (0-based) of a frame carrying word w.
   function automatic logic exp_line(input int dw, input int bc, input logic [7:0] w, input int c);
      int b;
      b = c / bc;
      if (b == 0) return 1'b0;
      if (b > dw) return 1'b1;
      return w[b-1];
   endfunction

   // Send one word on instance 'which', entered and left at a negedge.
   // mode 0: valid dropped after accept; 1: data and valid scrambled while
   // busy; 2: valid held high throughout.
   task automatic send(input int which, input logic [7:0] word, input int mode, input string tag);
      int         dw, bc, n, guard, glitch;
      logic [7:0] mask, rx;
      logic       q [$];
      dw = dw_a[which];
      bc = bc_a[which];
      n = (dw + 2) * bc;
      mask = 8'((1 << dw) - 1);
      guard = 0;
      while (!rdy_a[which] && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_ready"}, 32'(rdy_a[which]), 32'd1);
      dat_a[which] = word;
      vld_a[which] = 1'b1;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (mode == 0) vld_a[which] = 1'b0;
         if (mode == 1) begin
            vld_a[which] = 1'($urandom);
            dat_a[which] = 8'($urandom);
         end
         q.push_back(out_a[which]);
         check($sformatf("%s_c%0d", tag, i + 1),
               32'({out_a[which], busy_a[which], rdy_a[which], done_a[which]}),
               32'({exp_line(dw, bc, word & mask, i), 3'b100}));
      end
      @(negedge clk);
      if (mode != 2) vld_a[which] = 1'b0;
      check({tag, "_done"},
            32'({out_a[which], busy_a[which], rdy_a[which], done_a[which]}), 32'b1011);
      // Mid-bit sampling receiver.
      rx = '0;
      for (int j = 0; j < dw; j++) rx[j] = q[(j + 1) * bc + bc / 2];
      check({tag, "_start"}, 32'(q[bc / 2]), 32'd0);
      check({tag, "_stop"}, 32'(q[(dw + 1) * bc + bc / 2]), 32'd1);
      check({tag, "_rxword"}, 32'(rx), 32'(word & mask));
      glitch = 0;
      for (int p = 0; p < dw + 2; p++)
         for (int s = 1; s < bc; s++)
            if (q[p * bc + s] !== q[p * bc]) glitch++;
      check({tag, "_glitch"}, 32'(glitch), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   seen;
      logic [7:0] w;
      int   which, gap;
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vld_a[k] = 1'b0;
         dat_a[k] = 8'h00;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++)
         check($sformatf("reset_u%0d", k),
               32'({out_a[k], busy_a[k], rdy_a[k], done_a[k]}), 32'b1010);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      for (int k = 0; k < 3; k++)
         check($sformatf("post_reset_u%0d", k),
               32'({out_a[k], busy_a[k], rdy_a[k], done_a[k]}), 32'b1010);

      // Basic frame, then back-to-back with valid held high.
      send(0, 8'hA5, 0, "a5");
      send(0, 8'h01, 2, "b2b_01");
      send(0, 8'hFF, 2, "b2b_ff");
      vld_a[0] = 1'b0;
      @(negedge clk);

      // One bit per clock, 4-bit word.
      send(1, 8'h0C, 0, "bc1_c");
      @(negedge clk);

      // Inputs disturbed while busy.
      send(0, 8'h96, 1, "busy_ign");
      @(negedge clk);

      // Reset during the third data bit.
      dat_a[0] = 8'h5A;
      vld_a[0] = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         vld_a[0] = 1'b0;
      end
      check("abort_pre", 32'(out_a[0]), 32'(exp_line(8, 4, 8'h5A, 13)));
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("abort_line", 32'({out_a[0], busy_a[0], rdy_a[0], done_a[0]}), 32'b1010);
      rst = 1'b0;
      seen = 0;
      repeat (50) begin
         @(negedge clk);
         if (done_a[0] || !out_a[0]) seen++;
      end
      check("abort_nodone", 32'(seen), 32'd0);
      send(0, 8'h3C, 0, "post_abort");

      // Randomized scoreboard across all three configurations.
      for (int k = 0; k < 30; k++) begin
         which = $urandom_range(0, 2);
         gap = $urandom_range(0, 3);
         repeat (gap) @(negedge clk);
         w = 8'($urandom);
         send(which, w, $urandom_range(0, 1), $sformatf("rnd%0d_u%0d", k, which));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
